hamming_decoder_7_4: RTL and testbench

Streaming Hamming(7,4) decoder, the receive side of the team's `hamming_code` encoder. It accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome. It corrects any single-bit error, then delivers the 4 data bits with error flags through a 2-stage pipeline. A saturating counter tracks corrected words for link-quality monitoring.

---
 rtl/hamming_decoder_7_4_pkg.sv | 29 ++
 rtl/hamming_decoder_7_4_if.sv | 43 ++++
 rtl/hamming_decoder_7_4_syndrome.sv | 22 ++
 rtl/hamming_decoder_7_4.sv | 132 +++++++++++++
 tb/tb_hamming_decoder_7_4.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_decoder_7_4_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions, parity-check masks
// and small helpers used by the decoder and its syndrome logic.
package hamming_pkg;

  // Codeword bit index k holds Hamming position k+1.
  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned D0 = 2;
  localparam int unsigned P4 = 3;
  localparam int unsigned D1 = 4;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;

  localparam logic [6:0] MASK_S1 = 7'b1010101;
  localparam logic [6:0] MASK_S2 = 7'b1100110;
  localparam logic [6:0] MASK_S4 = 7'b1111000;

  typedef logic [2:0] syndrome_t;
  typedef logic [3:0] data_t;

  function automatic logic parity7(input logic [6:0] v);
    return ^v;
  endfunction

  function automatic data_t extract_data(input logic [6:0] code);
    return {code[D3], code[D2], code[D1], code[D0]};
  endfunction

endpackage

// File: rtl/hamming_decoder_7_4_if.sv
// Codeword-in / data-out streaming bus of the Hamming(7,4) decoder.
// master = upstream source plus downstream sink, slave = decoder.
interface hamming_decoder_7_4_if;
  import hamming_pkg::*;

  logic [6:0] code_in;
  logic       in_valid;
  logic       in_ready;
  logic       correct_en;
  data_t      data_out;
  syndrome_t  err_pos;
  logic       error_detected;
  logic       error_corrected;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output code_in,
    output in_valid,
    output correct_en,
    output out_ready,
    input  in_ready,
    input  data_out,
    input  err_pos,
    input  error_detected,
    input  error_corrected,
    input  out_valid
  );

  modport slave (
    input  code_in,
    input  in_valid,
    input  correct_en,
    input  out_ready,
    output in_ready,
    output data_out,
    output err_pos,
    output error_detected,
    output error_corrected,
    output out_valid
  );

endinterface

// File: rtl/hamming_decoder_7_4_syndrome.sv
// Combinational Hamming(7,4) check: syndrome of a codeword and the codeword
// with the indicated position inverted. Shared with the encoder's self-check.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [6:0] code,
  output syndrome_t  syndrome,
  output logic [6:0] corrected
);

  // Syndrome bits and single-bit repair of the addressed position
  always_comb begin
    syndrome  = {parity7(code & MASK_S4), parity7(code & MASK_S2), parity7(code & MASK_S1)};
    corrected = code;
    if (syndrome != 3'd0) begin
      corrected = code ^ (7'b0000001 << (syndrome - 3'd1));
    end else begin
      corrected = code;
    end
  end

endmodule

// File: rtl/hamming_decoder_7_4.sv
// Streaming Hamming(7,4) decoder: two-stage valid/ready pipeline with
// single-error correction and a saturating corrected-word counter.
module hamming_decoder_7_4
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  hamming_decoder_7_4_if.slave  bus,
  input  logic                  count_clr,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  syndrome_t        syn_s;
  logic [6:0]       fixed_s;

  logic             s1_valid_r;
  logic [6:0]       s1_code_r;
  logic [6:0]       s1_fixed_r;
  logic             s1_ce_r;
  syndrome_t        s1_syn_r;

  logic             s2_valid_r;
  data_t            s2_data_r;
  syndrome_t        s2_pos_r;
  logic             s2_det_r;
  logic             s2_cor_r;

  logic [CNT_W-1:0] err_count_r;

  logic             s1_advance_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             s2_load_s;
  data_t            s2_data_s;
  logic             s2_cor_s;

  hamming_syndrome u_syndrome (
    .code      (bus.code_in),
    .syndrome  (syn_s),
    .corrected (fixed_s)
  );

  // Handshake: S1 may hand over when S2 is empty or draining this cycle
  always_comb begin
    s1_advance_s = !s2_valid_r || bus.out_ready;
    in_ready_s   = !s1_valid_r || s1_advance_s;
    accept_s     = bus.in_valid && in_ready_s;
    s2_load_s    = s1_valid_r && s1_advance_s;
    s2_cor_s     = s1_ce_r && (s1_syn_r != 3'd0);
    if (s1_ce_r) begin
      s2_data_s = extract_data(s1_fixed_r);
    end else begin
      s2_data_s = extract_data(s1_code_r);
    end
  end

  // Stage 1: capture codeword, correction enable, syndrome and repaired word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_code_r  <= 7'd0;
      s1_fixed_r <= 7'd0;
      s1_ce_r    <= 1'b0;
      s1_syn_r   <= 3'd0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_code_r  <= bus.code_in;
      s1_fixed_r <= fixed_s;
      s1_ce_r    <= bus.correct_en;
      s1_syn_r   <= syn_s;
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: output register, held stable while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= 4'd0;
      s2_pos_r   <= 3'd0;
      s2_det_r   <= 1'b0;
      s2_cor_r   <= 1'b0;
    end else if (s1_advance_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= s2_data_s;
        s2_pos_r  <= s1_syn_r;
        s2_det_r  <= (s1_syn_r != 3'd0);
        s2_cor_r  <= s2_cor_s;
      end else begin
        s2_data_r <= s2_data_r;
        s2_pos_r  <= s2_pos_r;
        s2_det_r  <= s2_det_r;
        s2_cor_r  <= s2_cor_r;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Corrected-word counter; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= '0;
    end else if (count_clr) begin
      err_count_r <= '0;
    end else if (s2_load_s && s2_cor_s && (err_count_r != CNT_MAX)) begin
      err_count_r <= err_count_r + CNT_W'(1);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  // Drive the bus from the stage registers
  always_comb begin
    bus.in_ready        = in_ready_s;
    bus.out_valid       = s2_valid_r;
    bus.data_out        = s2_data_r;
    bus.err_pos         = s2_pos_r;
    bus.error_detected  = s2_det_r;
    bus.error_corrected = s2_cor_r;
    err_count           = err_count_r;
  end

endmodule

// File: tb/tb_hamming_decoder_7_4.sv
// Scoreboard bench for hamming_decoder_7_4: randomized codewords checked
// against an index-XOR Hamming reference model.
module tb_hamming_decoder_7_4;

  localparam int CNT_W   = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] pos;
    logic       det;
    logic       cor;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             count_clr;
  logic [CNT_W-1:0] err_count;

  hamming_decoder_7_4_if bus ();

  hamming_decoder_7_4 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .count_clr (count_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   occ     = 0;
  int   exp_cnt = 0;
  int   cyc     = 0;
  int   bp_mode = 0;
  logic [3:0] bp_pat = 4'b1001;
  exp_t held;
  bit   held_v = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: syndrome is the XOR of the positions of all set bits.
  function automatic exp_t ref_decode(input logic [6:0] c, input logic ce);
    exp_t r;
    int s = 0;
    logic [6:0] f;
    for (int k = 0; k < 7; k++) if (c[k]) s ^= (k + 1);
    f = c;
    if (ce && s != 0) f[s-1] = ~f[s-1];
    r.data = {f[6], f[5], f[4], f[2]};
    r.pos  = s[2:0];
    r.det  = (s != 0);
    r.cor  = ce && (s != 0);
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c = 7'd0;
    int p = 0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int k = 0; k < 7; k++) if (c[k]) p ^= (k + 1);
    c[0] = p[0]; c[1] = p[1]; c[3] = p[2];
    return c;
  endfunction

  function automatic logic [6:0] rand_word(input int max_flips);
    logic [6:0] c = encode(4'($urandom_range(0, 15)));
    int n = $urandom_range(0, max_flips);
    for (int i = 0; i < n; i++) c[$urandom_range(0, 6)] ^= 1'b1;
    return c;
  endfunction

  function automatic logic [6:0] one_err_word();
    logic [6:0] c = encode(4'($urandom_range(0, 15)));
    c[$urandom_range(0, 6)] ^= 1'b1;
    return c;
  endfunction

  // Issuer side: record accepted words, model occupancy and the counter
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ     = 0;
      exp_cnt = 0;
    end else begin
      exp_t e;
      bit acc, drn;
      acc = bus.in_valid && bus.in_ready;
      drn = bus.out_valid && bus.out_ready;
      check("in_ready", int'(bus.in_ready), int'((occ < 2) || bus.out_ready));
      e = ref_decode(bus.code_in, bus.correct_en);
      if (acc) exp_q.push_back(e);
      if (count_clr) exp_cnt = 0;
      else if (acc && e.cor && exp_cnt < CNT_SAT) exp_cnt++;
      occ += int'(acc) - int'(drn);
    end
  end

  // Monitor: compare delivered words and output stability under stall
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      exp_t cur;
      cur = '{bus.data_out, bus.err_pos, bus.error_detected, bus.error_corrected};
      if (held_v) check("hold_stable", int'(cur), int'(held));
      if (bus.out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", int'(cur.data), int'(e.data));
          check("err_pos", int'(cur.pos), int'(e.pos));
          check("error_detected", int'(cur.det), int'(e.det));
          check("error_corrected", int'(cur.cor), int'(e.cor));
        end
      end else begin
        held   = cur;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode == 1) bus.out_ready = bp_pat[cyc % 4];
    else if (bp_mode == 2) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [6:0] c, input logic ce);
    bit done = 1'b0;
    bus.code_in    = c;
    bus.correct_en = ce;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    bp_mode       = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
    tick();
    tick();
    check(name, int'(err_count), exp_cnt);
  endtask

  initial begin
    rst = 1'b0; count_clr = 1'b0;
    bus.in_valid = 1'b0; bus.code_in = 7'd0; bus.correct_en = 1'b0; bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_err_pos", int'(bus.err_pos), 0);
    check("rst_flags", int'({bus.error_detected, bus.error_corrected}), 0);
    check("rst_err_count", int'(err_count), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Clean word with latency check, then single data-bit errors
    send(7'b1010010, 1'b1);
    check("lat_n1_valid", int'(bus.out_valid), 0);
    tick();
    check("lat_n2_valid", int'(bus.out_valid), 1);
    drain("cnt_clean");
    send(7'b1000010, 1'b1);
    drain("cnt_pos5");
    check("cnt_one", int'(err_count), 1);
    send(7'b1100010, 1'b1);
    send(7'b1100010, 1'b0);
    drain("cnt_uncorrected");

    // Saturation, then clear colliding with a corrected word
    for (int i = 0; i < 4; i++) send(one_err_word(), 1'b1);
    drain("cnt_sat_model");
    check("cnt_saturated", int'(err_count), CNT_SAT);
    send(one_err_word(), 1'b1);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    drain("cnt_clr_sat");
    send(one_err_word(), 1'b1);
    send(one_err_word(), 1'b1);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    drain("cnt_clr_wins");

    // Backpressure pattern 1,0,0,1 over six words
    bp_mode = 1;
    for (int i = 0; i < 6; i++) send(rand_word(2), 1'b1);
    drain("cnt_bp");

    // Random traffic with random stalls and idle gaps
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(rand_word(2), 1'($urandom_range(0, 4) != 0));
    end
    drain("cnt_random");

    // Reset with both stages occupied
    bus.out_ready = 1'b0;
    send(one_err_word(), 1'b1);
    send(one_err_word(), 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_err_count", int'(err_count), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_output", int'(bus.out_valid), 0);
    end
    send(7'b1010010, 1'b1);
    drain("cnt_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
